wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Writer side of the general-purpose register file write port (we/waddr/wdata). Merges three result sources onto that single port:
  - in-order pipeline writeback;
  - the multi-cycle divider;
  - the load-miss return path.
- Keeps a pending-register scoreboard for long-latency destinations. ID uses it to stall dependent reads.
- Sits between the MEM/WB stage, the divider and the load unit on one side, and the register file on the other.

Parameters:
DATA_W, 32, data width of every write source and of rf_wdata
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers; width of pending mask

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; one clock domain, asynchronous assert, active-low (0 = reset)
wb_we  input  1  pipeline writeback valid; no backpressure, always accepted
wb_waddr  input  ADDR_W  pipeline destination register
wb_wdata  input  DATA_W  pipeline result
iss_valid  input  1  long-latency op (div or load-miss) issued this cycle
iss_waddr  input  ADDR_W  destination of issued long-latency op
div_valid  input  1  divider result valid; held until div_ready
div_ready  output  1  divider result accepted this cycle
div_waddr  input  ADDR_W  divider destination
div_wdata  input  DATA_W  divider result
ld_valid  input  1  load-miss result valid; held until ld_ready
ld_ready  output  1  load result accepted this cycle
ld_waddr  input  ADDR_W  load destination
ld_wdata  input  DATA_W  load data
chk_addr1  input  ADDR_W  ID read address 1
chk_addr2  input  ADDR_W  ID read address 2
busy1  output  1  chk_addr1 awaits a long-latency result
busy2  output  1  chk_addr2 awaits a long-latency result
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  ADDR_W  register-file write address (registered)
rf_wdata  output  DATA_W  register-file write data (registered)
pending  output  NUM_REGS  scoreboard mask (registered)

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - rf_we, rf_waddr and rf_wdata to 0;
  - the pending mask to 0;
  - the round-robin pointer to DIV.
- div_ready and ld_ready are 0 while in reset.
- Write-slot grant, one per cycle, combinational:
  - wb_we=1: pipeline wins; div_ready=0, ld_ready=0.
  - wb_we=0: round-robin between div_valid and ld_valid. If only one is valid, it wins. If both are valid, the pointer side wins.
  - The pointer flips to the other source after each div or ld grant. It is unchanged otherwise.
  - A ready is asserted only in a cycle where its own valid=1 and it is granted.
- Latency:
  - A winner in cycle N appears as rf_we=1 with its addr/data in cycle N+1, for exactly one cycle.
  - With no winner, rf_we=0 the next cycle; rf_waddr and rf_wdata hold their previous values.
- Register 0:
  - A grant with address 0 is consumed (ready pulses) but produces rf_we=0.
  - Register 0 is never pending; busy is never 1 for address 0.
- Scoreboard:
  - iss_valid sets pending[iss_waddr].
  - A div or ld grant clears pending[granted waddr] at the same edge that registers the write.
  - Set and clear of the same register in one cycle: the set wins, because a newer op now owns the register.
  - busyK = pending[chk_addrK] (registered mask, combinational index).
  - In the cycle rf_we carries the result, busy is already 0. The register file's same-cycle write bypass then supplies the value.
- Starvation: continuous wb_we starves div and ld. This is legal; ID stalls on busy drain the pipeline.
- WAW:
  - wb_we to a register whose pending bit is set leaves pending unchanged.
  - This is a pipeline-control bug; simulation assertion only.
- Reset mid-handshake: any held valid is re-arbitrated after reset release; nothing is committed during reset.

Decomposition:
- Shared defines in the common defines include: DATA_W/ADDR_W/NUM_REGS equivalents (RegBus, RegNumLog2, RegNum), ZeroWord, WriteEnable.
- Source-encoding constants SRC_WB, SRC_DIV and SRC_LD go in the same file.
- One natural sub-module: wb_scoreboard, holding the pending mask with its set/clear/check ports. Arbitration and output register stay in the top module.

Test Plan:
- Pipeline only: wb_we=1, waddr=5, wdata=0x1234 in cycle 0 -> cycle 1 rf_we=1, rf_waddr=5, rf_wdata=0x1234; cycle 2 rf_we=0.
- Issue then return: iss_valid to r8, then 3 cycles later div_valid r8=0xDEAD.
  - busy1 (chk_addr1=8) is 1 from the cycle after issue until the grant edge.
  - rf_we r8=0xDEAD follows; busy1=0 in that same cycle.
- Contention:
  - div and ld both valid, with wb_we=1 for 2 cycles: both readies stay 0.
  - Then, with the pointer at DIV: div is granted first, ld the next cycle. rf writes appear in that order, each 1 cycle after its grant.
- Register 0: ld_valid with waddr=0 -> ld_ready=1, rf_we stays 0, pending unchanged.
- Set/clear collision: div grant to r3 in the same cycle as iss_valid r3 -> pending[3]=1 afterwards; r3 written once.
- Async reset: rst=0 mid-cycle with pending=0x0000_0110 and rf_we=1 -> all outputs and pending go 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared widths, source encodings and the register-file write payload for the
// writeback arbiter and its scoreboard.
package wb_write_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam int unsigned RegBus     = DATA_W;
  localparam int unsigned RegNumLog2 = ADDR_W;
  localparam int unsigned RegNum     = NUM_REGS;

  localparam logic [RegBus-1:0] ZeroWord    = '0;
  localparam logic              WriteEnable = 1'b1;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_DIV  = 2'd2,
    SRC_LD   = 2'd3
  } src_e;

  // Which long-latency source wins the next div/ld tie.
  typedef enum logic {
    RR_DIV = 1'b0,
    RR_LD  = 1'b1
  } rr_e;

  typedef struct packed {
    logic                  we;
    logic [RegNumLog2-1:0] addr;
    logic [RegBus-1:0]     data;
  } rf_wr_t;

  function automatic logic is_zero_reg(input logic [RegNumLog2-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination mask for long-latency ops; ID reads it to stall operands
// whose producer has not yet written back.
module wb_scoreboard
  import wb_write_arbiter_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic [RegNumLog2-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [RegNumLog2-1:0] clr_addr_i,
  input  logic [RegNumLog2-1:0] chk_addr1_i,
  input  logic [RegNumLog2-1:0] chk_addr2_i,
  output logic                  busy1_o,
  output logic                  busy2_o,
  output logic [RegNum-1:0]     pending_o
);

  logic [RegNum-1:0] pending_q;
  logic [RegNum-1:0] pending_d;

  // Set is applied after clear: a newly issued op owns the register.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) begin
      pending_d[clr_addr_i] = 1'b0;
    end
    if (set_i) begin
      pending_d[set_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign busy1_o   = pending_q[chk_addr1_i];
  assign busy2_o   = pending_q[chk_addr2_i];
  assign pending_o = pending_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges pipeline writeback, divider and load-miss results onto the single
// register-file write port, and tracks pending long-latency destinations.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_waddr_i,
  input  logic [DATA_W-1:0]   wb_wdata_i,
  input  logic                iss_valid_i,
  input  logic [ADDR_W-1:0]   iss_waddr_i,
  input  logic                div_valid_i,
  output logic                div_ready_o,
  input  logic [ADDR_W-1:0]   div_waddr_i,
  input  logic [DATA_W-1:0]   div_wdata_i,
  input  logic                ld_valid_i,
  output logic                ld_ready_o,
  input  logic [ADDR_W-1:0]   ld_waddr_i,
  input  logic [DATA_W-1:0]   ld_wdata_i,
  input  logic [ADDR_W-1:0]   chk_addr1_i,
  input  logic [ADDR_W-1:0]   chk_addr2_i,
  output logic                busy1_o,
  output logic                busy2_o,
  output logic                rf_we_o,
  output logic [ADDR_W-1:0]   rf_waddr_o,
  output logic [DATA_W-1:0]   rf_wdata_o,
  output logic [NUM_REGS-1:0] pending_o
);

  rr_e              rr_q;
  rr_e              rr_d;
  src_e             src_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_data_c;
  logic             lat_grant_c;
  rf_wr_t           wr_q;
  rf_wr_t           wr_d;

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= RR_DIV;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Pointer moves to the other long-latency source after each div/ld grant.
  always_comb begin
    rr_d = rr_q;
    case (src_c)
      SRC_DIV: rr_d = RR_LD;
      SRC_LD:  rr_d = RR_DIV;
      default: rr_d = rr_q;
    endcase
  end

  // Grant: pipeline has absolute priority; div/ld ties resolved by pointer.
  always_comb begin
    src_c       = SRC_NONE;
    div_ready_o = 1'b0;
    ld_ready_o  = 1'b0;
    if (rst_ni) begin
      if (wb_we_i) begin
        src_c = SRC_WB;
      end else if (div_valid_i && ld_valid_i) begin
        src_c = (rr_q == RR_DIV) ? SRC_DIV : SRC_LD;
      end else if (div_valid_i) begin
        src_c = SRC_DIV;
      end else if (ld_valid_i) begin
        src_c = SRC_LD;
      end
    end
    div_ready_o = (src_c == SRC_DIV);
    ld_ready_o  = (src_c == SRC_LD);
  end

  always_comb begin
    sel_addr_c = '0;
    sel_data_c = ZeroWord;
    case (src_c)
      SRC_WB: begin
        sel_addr_c = wb_waddr_i;
        sel_data_c = wb_wdata_i;
      end
      SRC_DIV: begin
        sel_addr_c = div_waddr_i;
        sel_data_c = div_wdata_i;
      end
      SRC_LD: begin
        sel_addr_c = ld_waddr_i;
        sel_data_c = ld_wdata_i;
      end
      default: begin
        sel_addr_c = '0;
        sel_data_c = ZeroWord;
      end
    endcase
  end

  assign lat_grant_c = (src_c == SRC_DIV) || (src_c == SRC_LD);

  // Writes to r0 are consumed silently; address/data hold when nothing writes.
  always_comb begin
    wr_d.we   = 1'b0;
    wr_d.addr = wr_q.addr;
    wr_d.data = wr_q.data;
    if ((src_c != SRC_NONE) && !is_zero_reg(sel_addr_c)) begin
      wr_d.we   = WriteEnable;
      wr_d.addr = sel_addr_c;
      wr_d.data = sel_data_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
    end else begin
      wr_q <= wr_d;
    end
  end

  assign rf_we_o    = wr_q.we;
  assign rf_waddr_o = wr_q.addr;
  assign rf_wdata_o = wr_q.data;

  wb_scoreboard u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .set_i       (iss_valid_i),
    .set_addr_i  (iss_waddr_i),
    .clr_i       (lat_grant_c),
    .clr_addr_i  (sel_addr_c),
    .chk_addr1_i (chk_addr1_i),
    .chk_addr2_i (chk_addr2_i),
    .busy1_o     (busy1_o),
    .busy2_o     (busy2_o),
    .pending_o   (pending_o)
  );

  // A pipeline write over a still-pending destination means ID let a WAW slip.
  waw_hazard_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wb_we_i && pending_o[wb_waddr_i]))
    else $error("wb_write_arbiter: pipeline write to pending register %0d", wb_waddr_i);

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                wb_we_i = 1'b0;
  logic [ADDR_W-1:0]   wb_waddr_i = '0;
  logic [DATA_W-1:0]   wb_wdata_i = '0;
  logic                iss_valid_i = 1'b0;
  logic [ADDR_W-1:0]   iss_waddr_i = '0;
  logic                div_valid_i = 1'b0;
  logic                div_ready_o;
  logic [ADDR_W-1:0]   div_waddr_i = '0;
  logic [DATA_W-1:0]   div_wdata_i = '0;
  logic                ld_valid_i = 1'b0;
  logic                ld_ready_o;
  logic [ADDR_W-1:0]   ld_waddr_i = '0;
  logic [DATA_W-1:0]   ld_wdata_i = '0;
  logic [ADDR_W-1:0]   chk_addr1_i = '0;
  logic [ADDR_W-1:0]   chk_addr2_i = '0;
  logic                busy1_o;
  logic                busy2_o;
  logic                rf_we_o;
  logic [ADDR_W-1:0]   rf_waddr_o;
  logic [DATA_W-1:0]   rf_wdata_o;
  logic [NUM_REGS-1:0] pending_o;

  int n_checks = 0;
  int n_pass   = 0;

  wb_write_arbiter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wb_we_i     (wb_we_i),
    .wb_waddr_i  (wb_waddr_i),
    .wb_wdata_i  (wb_wdata_i),
    .iss_valid_i (iss_valid_i),
    .iss_waddr_i (iss_waddr_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .div_waddr_i (div_waddr_i),
    .div_wdata_i (div_wdata_i),
    .ld_valid_i  (ld_valid_i),
    .ld_ready_o  (ld_ready_o),
    .ld_waddr_i  (ld_waddr_i),
    .ld_wdata_i  (ld_wdata_i),
    .chk_addr1_i (chk_addr1_i),
    .chk_addr2_i (chk_addr2_i),
    .busy1_o     (busy1_o),
    .busy2_o     (busy2_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: state as it will be after the next rising edge.
  bit                m_pend [NUM_REGS];
  bit                m_ld_turn;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  always @(negedge clk_i) begin : cmp_p
    int                  g;
    logic [ADDR_W-1:0]   na;
    logic [DATA_W-1:0]   nd;
    logic [NUM_REGS-1:0] mask;
    if (!rst_ni) begin
      for (int r = 0; r < int'(NUM_REGS); r++) m_pend[r] = 1'b0;
      m_ld_turn = 1'b0;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      chk("rst_rf_we", 64'(rf_we_o), 64'(0));
      chk("rst_rf_waddr", 64'(rf_waddr_o), 64'(0));
      chk("rst_rf_wdata", 64'(rf_wdata_o), 64'(0));
      chk("rst_pending", 64'(pending_o), 64'(0));
      chk("rst_div_ready", 64'(div_ready_o), 64'(0));
      chk("rst_ld_ready", 64'(ld_ready_o), 64'(0));
    end else begin
      // 0 none, 1 pipeline, 2 divider, 3 load
      g = 0;
      if (wb_we_i) g = 1;
      else if (div_valid_i && ld_valid_i) g = m_ld_turn ? 3 : 2;
      else if (div_valid_i) g = 2;
      else if (ld_valid_i) g = 3;
      for (int r = 0; r < int'(NUM_REGS); r++) mask[r] = m_pend[r];
      chk("model_div_ready", 64'(div_ready_o), 64'(g == 2));
      chk("model_ld_ready", 64'(ld_ready_o), 64'(g == 3));
      chk("model_busy1", 64'(busy1_o), 64'(m_pend[chk_addr1_i]));
      chk("model_busy2", 64'(busy2_o), 64'(m_pend[chk_addr2_i]));
      chk("model_rf_we", 64'(rf_we_o), 64'(m_we));
      chk("model_rf_waddr", 64'(rf_waddr_o), 64'(m_addr));
      chk("model_rf_wdata", 64'(rf_wdata_o), 64'(m_data));
      chk("model_pending", 64'(pending_o), 64'(mask));
      na = (g == 1) ? wb_waddr_i : (g == 2) ? div_waddr_i : ld_waddr_i;
      nd = (g == 1) ? wb_wdata_i : (g == 2) ? div_wdata_i : ld_wdata_i;
      if (g != 0 && na != 0) begin
        m_we = 1'b1;
        m_addr = na;
        m_data = nd;
      end else begin
        m_we = 1'b0;
      end
      if (g >= 2) begin
        m_pend[na] = 1'b0;
        m_ld_turn = (g == 2);
      end
      if (iss_valid_i && iss_waddr_i != 0) m_pend[iss_waddr_i] = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim_p
    bit d_acc;
    bit l_acc;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_rf_we", 64'(rf_we_o), 64'(0));
    chk("reset_pending", 64'(pending_o), 64'(0));
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Pipeline only
    wb_we_i = 1'b1; wb_waddr_i = 5'd5; wb_wdata_i = 32'h1234;
    next_cycle();
    wb_we_i = 1'b0;
    chk("pipe_rf_we", 64'(rf_we_o), 64'(1));
    chk("pipe_rf_waddr", 64'(rf_waddr_o), 64'(5));
    chk("pipe_rf_wdata", 64'(rf_wdata_o), 64'(32'h1234));
    next_cycle();
    chk("pipe_rf_we_drop", 64'(rf_we_o), 64'(0));
    chk("pipe_rf_waddr_hold", 64'(rf_waddr_o), 64'(5));

    // Issue then return
    iss_valid_i = 1'b1; iss_waddr_i = 5'd8; chk_addr1_i = 5'd8;
    #1 chk("iss_busy_before", 64'(busy1_o), 64'(0));
    next_cycle();
    iss_valid_i = 1'b0;
    chk("iss_busy_c1", 64'(busy1_o), 64'(1));
    next_cycle();
    chk("iss_busy_c2", 64'(busy1_o), 64'(1));
    next_cycle();
    div_valid_i = 1'b1; div_waddr_i = 5'd8; div_wdata_i = 32'hDEAD;
    #1;
    chk("ret_div_ready", 64'(div_ready_o), 64'(1));
    chk("ret_busy_grant", 64'(busy1_o), 64'(1));
    next_cycle();
    div_valid_i = 1'b0;
    chk("ret_rf_we", 64'(rf_we_o), 64'(1));
    chk("ret_rf_waddr", 64'(rf_waddr_o), 64'(8));
    chk("ret_rf_wdata", 64'(rf_wdata_o), 64'(32'hDEAD));
    chk("ret_busy_clear", 64'(busy1_o), 64'(0));

    // Register 0 via the load path (also returns the pointer to DIV)
    ld_valid_i = 1'b1; ld_waddr_i = 5'd0; ld_wdata_i = 32'hBAD;
    #1 chk("r0_ld_ready", 64'(ld_ready_o), 64'(1));
    next_cycle();
    ld_valid_i = 1'b0;
    chk("r0_rf_we", 64'(rf_we_o), 64'(0));
    chk("r0_pending", 64'(pending_o), 64'(0));

    // Contention under pipeline starvation, then round-robin drain
    wb_we_i = 1'b1; wb_waddr_i = 5'd1; wb_wdata_i = 32'h11;
    div_valid_i = 1'b1; div_waddr_i = 5'd9; div_wdata_i = 32'h99;
    ld_valid_i = 1'b1; ld_waddr_i = 5'd10; ld_wdata_i = 32'hAA;
    #1;
    chk("cont_div_ready_c0", 64'(div_ready_o), 64'(0));
    chk("cont_ld_ready_c0", 64'(ld_ready_o), 64'(0));
    next_cycle();
    chk("cont_div_ready_c1", 64'(div_ready_o), 64'(0));
    chk("cont_ld_ready_c1", 64'(ld_ready_o), 64'(0));
    next_cycle();
    wb_we_i = 1'b0;
    #1;
    chk("cont_div_first", 64'(div_ready_o), 64'(1));
    chk("cont_ld_wait", 64'(ld_ready_o), 64'(0));
    next_cycle();
    div_valid_i = 1'b0;
    #1;
    chk("cont_ld_second", 64'(ld_ready_o), 64'(1));
    chk("cont_rf_div_addr", 64'(rf_waddr_o), 64'(9));
    chk("cont_rf_div_data", 64'(rf_wdata_o), 64'(32'h99));
    next_cycle();
    ld_valid_i = 1'b0;
    chk("cont_rf_ld_we", 64'(rf_we_o), 64'(1));
    chk("cont_rf_ld_addr", 64'(rf_waddr_o), 64'(10));
    chk("cont_rf_ld_data", 64'(rf_wdata_o), 64'(32'hAA));

    // Set/clear collision on r3
    div_valid_i = 1'b1; div_waddr_i = 5'd3; div_wdata_i = 32'h33;
    iss_valid_i = 1'b1; iss_waddr_i = 5'd3;
    #1 chk("coll_div_ready", 64'(div_ready_o), 64'(1));
    next_cycle();
    div_valid_i = 1'b0; iss_valid_i = 1'b0;
    chk("coll_pending", 64'(pending_o), 64'(32'h8));
    chk("coll_rf_addr", 64'(rf_waddr_o), 64'(3));
    next_cycle();
    chk("coll_single_write", 64'(rf_we_o), 64'(0));

    // Build pending=0x110 with a write in flight, then async reset mid-cycle
    iss_valid_i = 1'b1; iss_waddr_i = 5'd4;
    div_valid_i = 1'b1; div_waddr_i = 5'd3; div_wdata_i = 32'h3333;
    next_cycle();
    div_valid_i = 1'b0; iss_waddr_i = 5'd8;
    wb_we_i = 1'b1; wb_waddr_i = 5'd2; wb_wdata_i = 32'h22;
    next_cycle();
    iss_valid_i = 1'b0; wb_we_i = 1'b0;
    chk("pre_rst_pending", 64'(pending_o), 64'(32'h110));
    chk("pre_rst_rf_we", 64'(rf_we_o), 64'(1));
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_rf_we", 64'(rf_we_o), 64'(0));
    chk("arst_rf_waddr", 64'(rf_waddr_o), 64'(0));
    chk("arst_rf_wdata", 64'(rf_wdata_o), 64'(0));
    chk("arst_pending", 64'(pending_o), 64'(0));
    chk("arst_busy1", 64'(busy1_o), 64'(0));
    ld_valid_i = 1'b1; ld_waddr_i = 5'd7; ld_wdata_i = 32'h77;
    #1 chk("arst_ld_ready", 64'(ld_ready_o), 64'(0));
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
    #1 chk("post_rst_ld_ready", 64'(ld_ready_o), 64'(1));
    next_cycle();
    ld_valid_i = 1'b0;
    chk("post_rst_rf_addr", 64'(rf_waddr_o), 64'(7));
    chk("post_rst_rf_data", 64'(rf_wdata_o), 64'(32'h77));

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      d_acc = div_ready_o;
      l_acc = ld_ready_o;
      next_cycle();
      iss_valid_i = ($urandom_range(0, 9) < 3);
      iss_waddr_i = ADDR_W'($urandom);
      if (!div_valid_i || d_acc) begin
        div_valid_i = ($urandom_range(0, 3) == 0);
        div_waddr_i = ADDR_W'($urandom);
        div_wdata_i = DATA_W'($urandom);
      end
      if (!ld_valid_i || l_acc) begin
        ld_valid_i = ($urandom_range(0, 3) == 0);
        ld_waddr_i = ADDR_W'($urandom);
        ld_wdata_i = DATA_W'($urandom);
      end
      wb_waddr_i = ADDR_W'($urandom);
      wb_wdata_i = DATA_W'($urandom);
      wb_we_i = ($urandom_range(0, 9) < 4) && !pending_o[wb_waddr_i];
      chk_addr1_i = ADDR_W'($urandom);
      chk_addr2_i = ADDR_W'($urandom);
      if (i % 700 == 699) begin
        #1 rst_ni = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
      end
    end

    @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
